// File: rtl/channel_seq.sv
// channel_seq: table-driven measurement channel sequencer with MCU readback.
// Optional sync watchdog is built when CHANNEL_SEQ_TIMEOUT_EN is defined.
module channel_seq #(
  parameter int N_IN = 18,
  parameter int SEL_W = 5,
  parameter int N_CH = 25,
  parameter int CH_W = 5,
  parameter int ADDR_W = 20,
  parameter int PAGE_LOG2 = 12,
  parameter logic [ADDR_W-1:0] ADDR_IDLE = 20'h7fff0,
  parameter int TO_CYC = 1000000,
  localparam int ENTRY_W = 2*SEL_W+10
) (
  input  logic               clk,
  input  logic               mcu_n_rst,
  input  logic [N_IN-1:0]    ch_sgn_in,
  input  logic               ch_sync_in,
  input  logic               mcu_start,
  input  logic [2:0]         mcu_data_sel,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_wdata,
  input  logic [7:0]         mem_data,
  input  logic [15:0]        pulse_cnt,
  input  logic [31:0]        clk_cnt,
  output logic               ch_sgn_out,
  output logic               ch_sync_out,
  output logic               sample_en,
  output logic               mcu_end,
  output logic [7:0]         sync_cnt_out,
  output logic [ADDR_W-1:0]  addr_base,
  output logic [7:0]         mcu_data,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NX = 1 << SEL_W;
  localparam logic [7:0] NCH = 8'(N_CH);
  localparam logic [CH_W:0] NCH_A = (CH_W+1)'(N_CH);

  state_t state;
  logic [7:0] sync_cnt;
  logic s1, s2, s3;
  logic t1, t2, t3;
  logic sync_edge;
  logic start_edge;
  logic [ENTRY_W-1:0] tbl [N_CH];
  logic active;
  logic wr_ok;
  logic [CH_W-1:0] idx;
  logic [ENTRY_W-1:0] ent;
  logic [7:0] page;
  logic [1:0] mode;
  logic [SEL_W-1:0] src_a;
  logic [SEL_W-1:0] src_b;
  logic [NX-1:0] in_ext;
  logic a_bit;
  logic b_bit;
  logic sgn;

  assign sync_edge = s2 & ~s3;
  assign start_edge = t2 & ~t3;
  assign active = (state == RUN) && (sync_cnt != 8'd0)
                  && (sync_cnt <= NCH);
  assign idx = CH_W'(sync_cnt - 8'd1);
  assign ent = active ? tbl[idx] : '0;
  assign {page, mode, src_b, src_a} = ent;

  // Zero-extending the inputs makes out-of-range sources read as 0.
  assign in_ext = NX'(ch_sgn_in);
  assign a_bit = in_ext[src_a];
  assign b_bit = in_ext[src_b];

  always_comb begin
    sgn = 1'b0;
    unique case (mode)
      2'b00: sgn = 1'b0;
      2'b01: sgn = a_bit;
      2'b10: sgn = a_bit ^ b_bit;
      2'b11: sgn = ~a_bit;
    endcase
  end

  assign wr_ok = cfg_we && (state != RUN)
                 && ({1'b0, cfg_addr} < NCH_A);

  always_ff @(posedge clk) begin
    if (!mcu_n_rst) begin
      for (int i = 0; i < N_CH; i++) tbl[i] <= '0;
    end else if (wr_ok) begin
      tbl[cfg_addr] <= cfg_wdata;
    end
  end

`ifdef CHANNEL_SEQ_TIMEOUT_EN
  localparam logic [23:0] TO_LIM = 24'(TO_CYC - 1);
  logic [23:0] wdog;
`else
  logic unused_to;
  assign unused_to = TO_CYC[0];
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!mcu_n_rst) begin
      {s1, s2, s3} <= '0;
      {t1, t2, t3} <= '0;
      state <= IDLE;
      sync_cnt <= '0;
      ch_sgn_out <= 1'b0;
      ch_sync_out <= 1'b0;
      addr_base <= ADDR_IDLE;
`ifdef CHANNEL_SEQ_TIMEOUT_EN
      wdog <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      s1 <= ch_sync_in;
      s2 <= s1;
      s3 <= s2;
      t1 <= mcu_start;
      t2 <= t1;
      t3 <= t2;
      ch_sync_out <= s2 & (state == RUN);
      ch_sgn_out <= active & sgn;
      addr_base <= active ? ADDR_W'({page, {PAGE_LOG2{1'b0}}})
                          : ADDR_IDLE;
`ifdef CHANNEL_SEQ_TIMEOUT_EN
      wdog <= (state == RUN && !sync_edge) ? wdog + 24'd1 : '0;
`endif
      unique case (state)
        IDLE: begin
          sync_cnt <= '0;
          if (start_edge) state <= RUN;
        end
        RUN: begin
          if (sync_edge) begin
            if (sync_cnt < NCH) begin
              sync_cnt <= sync_cnt + 8'd1;
            end else begin
              sync_cnt <= '0;
              state <= DONE;
            end
          end
`ifdef CHANNEL_SEQ_TIMEOUT_EN
          else if (wdog == TO_LIM) begin
            sync_cnt <= '0;
            state <= DONE;
            timeout_err <= 1'b1;
          end
`endif
        end
        DONE: begin
          if (start_edge) begin
            state <= RUN;
            sync_cnt <= '0;
`ifdef CHANNEL_SEQ_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sync_cnt_out = sync_cnt;
  assign sample_en = (state == RUN) || (state == DONE);
  assign mcu_end = (state == DONE);

  always_comb begin
    mcu_data = 8'h00;
    if (mcu_end) begin
      mcu_data = mem_data;
    end else begin
      unique case (mcu_data_sel)
        3'd0: mcu_data = sync_cnt;
        3'd1: mcu_data = pulse_cnt[7:0];
        3'd2: mcu_data = pulse_cnt[15:8];
        3'd3: mcu_data = clk_cnt[7:0];
        3'd4: mcu_data = clk_cnt[15:8];
        3'd5: mcu_data = clk_cnt[23:16];
        3'd6: mcu_data = clk_cnt[31:24];
        3'd7: mcu_data = {3'b001, timeout_err, mcu_end,
                          sample_en, state};
      endcase
    end
  end

endmodule

// File: tb/tb_channel_seq.sv
// Bench for channel_seq: readback mux vector table, directed sequences,
// and randomized per-channel checks against a table-level model.
module tb_channel_seq;
  localparam int N_IN = 18;
  localparam int N_CH = 25;

  logic clk;
  logic mcu_n_rst;
  logic [N_IN-1:0] ch_sgn_in;
  logic ch_sync_in;
  logic mcu_start;
  logic [2:0] mcu_data_sel;
  logic cfg_we;
  logic [4:0] cfg_addr;
  logic [19:0] cfg_wdata;
  logic [7:0] mem_data;
  logic [15:0] pulse_cnt;
  logic [31:0] clk_cnt;
  logic ch_sgn_out;
  logic ch_sync_out;
  logic sample_en;
  logic mcu_end;
  logic [7:0] sync_cnt_out;
  logic [19:0] addr_base;
  logic [7:0] mcu_data;
  logic timeout_err;

  channel_seq dut (
    .clk(clk), .mcu_n_rst(mcu_n_rst), .ch_sgn_in(ch_sgn_in),
    .ch_sync_in(ch_sync_in), .mcu_start(mcu_start),
    .mcu_data_sel(mcu_data_sel), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .mem_data(mem_data), .pulse_cnt(pulse_cnt), .clk_cnt(clk_cnt),
    .ch_sgn_out(ch_sgn_out), .ch_sync_out(ch_sync_out),
    .sample_en(sample_en), .mcu_end(mcu_end),
    .sync_cnt_out(sync_cnt_out), .addr_base(addr_base),
    .mcu_data(mcu_data), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] pc;
    logic [31:0] cc;
    logic [7:0]  exp;
  } rb_t;

  int checks = 0;
  int fails = 0;
  logic [19:0] mtab [N_CH];
  int mst;
  int mcnt;
  rb_t rb [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [19:0] mk(input logic [7:0] pg,
    input logic [1:0] md, input logic [4:0] b, input logic [4:0] a);
    return {pg, md, b, a};
  endfunction

  function automatic logic bitof(input logic [N_IN-1:0] v, input int s);
    logic [31:0] t;
    t = 32'(v) >> s;
    return (s < N_IN) && t[0];
  endfunction

  function automatic logic is_active();
    return mst == 1 && mcnt >= 1 && mcnt <= N_CH;
  endfunction

  function automatic logic exp_sgn(input logic [N_IN-1:0] v);
    logic [19:0] e;
    int a;
    int b;
    if (!is_active()) return 1'b0;
    e = mtab[mcnt-1];
    a = int'(e[4:0]);
    b = int'(e[9:5]);
    case (e[11:10])
      2'd0: return 1'b0;
      2'd1: return bitof(v, a);
      2'd2: return bitof(v, a) ^ bitof(v, b);
      default: return !bitof(v, a);
    endcase
  endfunction

  function automatic logic [19:0] exp_addr();
    logic [19:0] e;
    if (!is_active()) return 20'h7fff0;
    e = mtab[mcnt-1];
    return {e[19:12], 12'h000};
  endfunction

  task automatic wr(input int a, input logic [19:0] d);
    cfg_we = 1'b1;
    cfg_addr = 5'(a);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (mst != 1 && a < N_CH) mtab[a] = d;
  endtask

  task automatic pulse();
    ch_sync_in = 1'b1;
    cyc(3);
    ch_sync_in = 1'b0;
    cyc(3);
    if (mst == 1) begin
      if (mcnt < N_CH) mcnt++;
      else begin
        mcnt = 0;
        mst = 2;
      end
    end
  endtask

  task automatic start();
    mcu_start = 1'b1;
    cyc(3);
    mcu_start = 1'b0;
    cyc(3);
    if (mst != 1) begin
      mst = 1;
      mcnt = 0;
    end
  endtask

  task automatic state_chk(input string tag);
    chk({tag, "_cnt"}, sync_cnt_out, mcnt);
    chk({tag, "_end"}, mcu_end, mst == 2);
    chk({tag, "_sen"}, sample_en, mst != 0);
    chk({tag, "_addr"}, addr_base, exp_addr());
    chk({tag, "_terr"}, timeout_err, 0);
  endtask

  task automatic chan_chk(input string tag, input logic [N_IN-1:0] v);
    ch_sgn_in = v;
    @(negedge clk);
    chk({tag, "_sgn"}, ch_sgn_out, exp_sgn(v));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N_IN-1:0] v;
    mcu_n_rst = 1'b0;
    ch_sgn_in = '0;
    ch_sync_in = 1'b0;
    mcu_start = 1'b0;
    mcu_data_sel = 3'd0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    mem_data = '0;
    pulse_cnt = '0;
    clk_cnt = '0;
    mst = 0;
    mcnt = 0;
    for (int i = 0; i < N_CH; i++) mtab[i] = '0;
    rb[0] = '{3'd0, 16'ha55a, 32'h89abcdef, 8'h00};
    rb[1] = '{3'd1, 16'ha55a, 32'h89abcdef, 8'h5a};
    rb[2] = '{3'd2, 16'ha55a, 32'h89abcdef, 8'ha5};
    rb[3] = '{3'd3, 16'ha55a, 32'h89abcdef, 8'hef};
    rb[4] = '{3'd4, 16'ha55a, 32'h89abcdef, 8'hcd};
    rb[5] = '{3'd5, 16'ha55a, 32'h89abcdef, 8'hab};
    rb[6] = '{3'd6, 16'ha55a, 32'h89abcdef, 8'h89};
    rb[7] = '{3'd7, 16'ha55a, 32'h89abcdef, 8'h20};
    cyc(3);
    mcu_n_rst = 1'b1;
    cyc(1);

    chk("rst_sgn", ch_sgn_out, 0);
    chk("rst_sync", ch_sync_out, 0);
    state_chk("rst");

    for (int i = 0; i < 8; i++) begin
      mcu_data_sel = rb[i].sel;
      pulse_cnt = rb[i].pc;
      clk_cnt = rb[i].cc;
      #1;
      chk($sformatf("rb_sel%0d", i), mcu_data, rb[i].exp);
    end
    @(negedge clk);

    wr(0, mk(8'h01, 2'b01, 5'd0, 5'd3));
    wr(1, mk(8'h02, 2'b10, 5'd11, 5'd9));
    wr(2, mk(8'h03, 2'b11, 5'd0, 5'd20));
    wr(3, mk(8'h04, 2'b01, 5'd0, 5'd5));
    for (int i = 4; i < N_CH; i++) wr(i, 20'($urandom));
    wr(25, 20'hfffff);
    wr(31, 20'hfffff);

    start();
    state_chk("run0");
    mcu_data_sel = 3'd7;
    #1;
    chk("status_run", mcu_data, 8'h25);

    // first pulse: check the 3-cycle ch_sync_out lag by hand
    ch_sync_in = 1'b1;
    @(negedge clk);
    chk("sync_lag1", ch_sync_out, 0);
    @(negedge clk);
    chk("sync_lag2", ch_sync_out, 0);
    @(negedge clk);
    chk("sync_lag3", ch_sync_out, 1);
    ch_sync_in = 1'b0;
    cyc(3);
    mcnt = 1;
    state_chk("ch1");
    chk("ch1_addr_k", addr_base, 20'h01000);
    mcu_data_sel = 3'd0;
    #1;
    chk("ch1_rd", mcu_data, 8'd1);
    for (int i = 0; i < 6; i++) begin
      v = N_IN'($urandom);
      v[3] = i[0];
      chan_chk("ch1", v);
      chk("ch1_k", ch_sgn_out, i[0]);
    end

    pulse();
    state_chk("ch2");
    for (int i = 0; i < 4; i++) begin
      v = N_IN'($urandom);
      v[9] = i[0];
      v[11] = i[1];
      chan_chk("ch2", v);
      chk("ch2_k", ch_sgn_out, i[0] ^ i[1]);
    end

    pulse();
    state_chk("ch3");
    chk("ch3_addr_k", addr_base, 20'h03000);
    for (int i = 0; i < 3; i++) begin
      chan_chk("ch3", N_IN'($urandom));
      chk("ch3_k", ch_sgn_out, 1);
    end

    wr(3, mk(8'h44, 2'b00, 5'd0, 5'd0));
    pulse();
    state_chk("ch4");
    chk("ch4_addr_k", addr_base, 20'h04000);
    chan_chk("ch4a", 18'h00020);
    chk("ch4_old_entry", ch_sgn_out, 1);
    chan_chk("ch4b", 18'h3ffdf);

    while (mcnt < N_CH) begin
      pulse();
      state_chk($sformatf("ch%0d", mcnt));
      for (int i = 0; i < 3; i++)
        chan_chk($sformatf("ch%0d", mcnt), N_IN'($urandom));
    end

    pulse();
    state_chk("done");
    chk("done_k_end", mcu_end, 1);
    chan_chk("done", '1);
    for (int i = 0; i < 3; i++) begin
      mem_data = 8'($urandom);
      mcu_data_sel = 3'($urandom);
      #1;
      chk("done_mem", mcu_data, mem_data);
    end
    @(negedge clk);

    wr(0, mk(8'h10, 2'b11, 5'd0, 5'd3));
    start();
    state_chk("restart");
    chk("restart_end", mcu_end, 0);
    pulse();
    state_chk("rs_ch1");
    chan_chk("rs_ch1a", 18'h00008);
    chk("rs_ch1_k", ch_sgn_out, 0);
    chan_chk("rs_ch1b", 18'h00000);

    pulse();
    mcu_n_rst = 1'b0;
    @(negedge clk);
    mst = 0;
    mcnt = 0;
    for (int i = 0; i < N_CH; i++) mtab[i] = '0;
    chk("abort_sen", sample_en, 0);
    chk("abort_cnt", sync_cnt_out, 0);
    chk("abort_addr", addr_base, 20'h7fff0);
    chk("abort_sgn", ch_sgn_out, 0);
    mcu_n_rst = 1'b1;
    @(negedge clk);
    pulse();
    state_chk("ign");

    // table write and start request in the same cycle
    cfg_we = 1'b1;
    cfg_addr = 5'd1;
    cfg_wdata = mk(8'h20, 2'b01, 5'd0, 5'd0);
    mcu_start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    mtab[1] = mk(8'h20, 2'b01, 5'd0, 5'd0);
    cyc(2);
    mcu_start = 1'b0;
    cyc(3);
    mst = 1;
    mcnt = 0;
    state_chk("ws_run");
    pulse();
    state_chk("ws_ch1");
    chan_chk("ws_ch1", '1);
    chk("ws_cleared", ch_sgn_out, 0);
    pulse();
    state_chk("ws_ch2");
    chk("ws_addr_k", addr_base, 20'h20000);
    chan_chk("ws_ch2a", 18'h00001);
    chk("ws_ch2_k", ch_sgn_out, 1);
    chan_chk("ws_ch2b", 18'h3fffe);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
